// File: rtl/qpsk_pkg.sv
// Shared constants for the QPSK datapath: frame geometry and the packer's
// frame-path state encoding.
package qpsk_pkg;
    localparam int FRAME_W         = 40;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_FRAME = 5;
    localparam int BYTE_CNT_W      = $clog2(BYTES_PER_FRAME);

    typedef enum logic {
        FILLING = 1'b0,
        FULL    = 1'b1
    } frame_state_e;
endpackage

// File: rtl/qpsk_slot_timer.sv
// Free-running frame-slot counter; tick marks the last cycle of every slot.
module qpsk_slot_timer #(
    parameter int FRAME_CYCLES = 2000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CNT_W = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] slot_cnt_q;
    logic [CNT_W-1:0] slot_cnt_d;

    always_comb begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        if (slot_cnt_q == LAST) begin
            slot_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
        end
    end

    assign tick = (slot_cnt_q == LAST);
endmodule

// File: rtl/qpsk_frame_packer.sv
// Packs a handshaked byte stream MSB-first into 40-bit frames and presents
// them to the modulator on a fixed slot grid, filling empty slots with IDLE_WORD.
module qpsk_frame_packer
    import qpsk_pkg::*;
#(
    parameter int                 FRAME_CYCLES = 2000,
    parameter logic [FRAME_W-1:0] IDLE_WORD    = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BYTE_W-1:0]  byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic [FRAME_W-1:0] para_out,
    output logic               frame_start,
    output logic               idle_ins
);
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_FRAME - 1);

    frame_state_e           state_q;
    logic [BYTE_CNT_W-1:0]  byte_cnt_q;
    logic [BYTE_W-1:0]      lane_q [BYTES_PER_FRAME];
    logic [FRAME_W-1:0]     asm_w;
    logic [FRAME_W-1:0]     para_q;
    logic                   frame_start_q;
    logic                   idle_ins_q;
    logic                   tick;
    logic                   accept;

    qpsk_slot_timer #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_slot_timer (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign byte_ready = (state_q == FILLING) && !rst;
    assign accept     = byte_valid && byte_ready;

    // Lane 0 is the first byte of a frame and lands in the top bits.
    for (genvar gi = 0; gi < BYTES_PER_FRAME; gi++) begin : g_lane
        always_ff @(posedge clk) begin
            if (rst) begin
                lane_q[gi] <= '0;
            end else if (accept && byte_cnt_q == BYTE_CNT_W'(gi)) begin
                lane_q[gi] <= byte_in;
            end
        end
        assign asm_w[FRAME_W-1-BYTE_W*gi -: BYTE_W] = lane_q[gi];
    end

    // The boundary load looks at the pre-edge state, so a frame completed on
    // the tick cycle itself waits for the next boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILLING;
            byte_cnt_q    <= '0;
            para_q        <= IDLE_WORD;
            frame_start_q <= 1'b0;
            idle_ins_q    <= 1'b0;
        end else begin
            frame_start_q <= tick;
            idle_ins_q    <= 1'b0;
            if (tick) begin
                if (state_q == FULL) begin
                    para_q <= asm_w;
                end else begin
                    para_q     <= IDLE_WORD;
                    idle_ins_q <= 1'b1;
                end
            end
            case (state_q)
                FILLING: begin
                    if (accept) begin
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_q <= '0;
                            state_q    <= FULL;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (tick) begin
                        state_q <= FILLING;
                    end
                end
                default: state_q <= FILLING;
            endcase
        end
    end

    assign para_out    = para_q;
    assign frame_start = frame_start_q;
    assign idle_ins    = idle_ins_q;
endmodule
